// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Holds the FIFO entry layout, fetch FSM states and word size.
package fetch_pkg;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; push+pop is legal when full.
// Ports: clk, rst_n, push, pop, flush, din, dout (head), full, empty, count.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential requests, in-order
// response capture into a {pc,instr} FIFO, redirect flush with stale drain.
// Ports: clk, reset (async, active-low); mem_req_valid/ready/addr;
// mem_rsp_valid/data; instr_valid/ready, instr, instr_pc; redirect, redirect_pc.
// Macro FETCH_PERF_EN adds perf_fetched and perf_flushes counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
`ifdef FETCH_PERF_EN
    input  logic [31:0] redirect_pc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushes
`else
    input  logic [31:0] redirect_pc
`endif
);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    fetch_entry_t  last_q, last_d;

    fetch_entry_t  fifo_din, fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   pcq_dout;
    logic          pcq_full, pcq_empty;
    logic [CW-1:0] pcq_count;

    logic          credit, accept, rsp_keep, pop;
    logic          unused_ok;

    // Buffered entries plus in-flight requests never exceed DEPTH,
    // so every response is guaranteed a FIFO slot.
    assign credit        = ({1'b0, fifo_count} + {1'b0, outst_q}) < LIMIT;
    assign mem_req_valid = reset && (state_q == FETCH) && !redirect && credit;
    assign mem_req_addr  = fetch_pc_q;
    assign accept        = mem_req_valid && mem_req_ready;
    assign rsp_keep      = mem_rsp_valid && (discard_q == '0);

    assign instr_valid   = !fifo_empty;
    assign pop           = instr_valid && instr_ready && !redirect;
    // With the FIFO empty the last popped entry stays visible.
    assign instr         = fifo_empty ? last_q.instr : fifo_dout.instr;
    assign instr_pc      = fifo_empty ? last_q.pc : fifo_dout.pc;

    assign fifo_din      = '{pc: pcq_dout, instr: mem_rsp_data};
    assign unused_ok     = ^{fifo_full, pcq_full, pcq_empty, pcq_count};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_entry_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (rsp_keep),
        .pop   (pop),
        .flush (redirect),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [31:0])
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (reset),
        .push  (accept),
        .pop   (rsp_keep),
        .flush (redirect),
        .din   (fetch_pc_q),
        .dout  (pcq_dout),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(accept) - CW'(mem_rsp_valid);
        discard_d  = discard_q;
        last_d     = last_q;
        if (mem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
        unique case (state_q)
            FETCH: if (accept) fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
            DRAIN: if (discard_d == '0) state_d = FETCH;
        endcase
        // Everything still unanswered after this edge is stale.
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'(WORD_BYTES - 1);
            discard_d  = outst_d;
            state_d    = (outst_d != '0) ? DRAIN : FETCH;
        end
        if (pop) last_d = fifo_dout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            last_q     <= last_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushes_q, flushes_d;

    always_comb begin
        fetched_d = fetched_q + 32'(pop);
        flushes_d = flushes_q + 32'(redirect);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_q <= '0;
            flushes_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushes_q <= flushes_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus redirect/stall/wrap/reset sequences.
// Memory model returns addr+0x100 after a configurable fixed latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
`endif

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redirect      (redirect),
`ifdef FETCH_PERF_EN
        .redirect_pc   (redirect_pc),
        .perf_fetched  (perf_fetched),
        .perf_flushes  (perf_flushes)
`else
        .redirect_pc   (redirect_pc)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: in-order, fixed latency, one response per accepted request.
    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        mq[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned last_due = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) mq.delete();
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mq[0].data;
                void'(mq.pop_front());
            end
            #2;
            if (mem_req_valid && mem_req_ready) begin
                int unsigned d;
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq.push_back('{due: d, data: mem_req_addr + 32'h100});
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Returns at cycle 0: the negedge where reset is released.
    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string nm, output logic [31:0] pc,
                              output logic [31:0] ins);
        int n;
        n = 0;
        while (!instr_valid && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_seen"}, 32'(instr_valid), 32'd1);
        pc  = instr_pc;
        ins = instr;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({nm, "_req_addr"}, mem_req_addr, 32'h0);
        chk({nm, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({nm, "_instr"}, instr, 32'h0);
        chk({nm, "_instr_pc"}, instr_pc, 32'h0);
    endtask

    typedef struct {
        logic        rst;
        logic        ir;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] ins;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic ir, input logic rv,
                                input logic [31:0] ra, input logic iv,
                                input logic [31:0] ipc, input logic [31:0] ins);
        vec_t v;
        v.rst = rst; v.ir = ir; v.rv = rv; v.ra = ra;
        v.iv = iv; v.ipc = ipc; v.ins = ins;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        logic [31:0] pc, ins, exp_addr, exp_pc;
        logic [15:0] pat;

        // Streaming with the core always ready.
        vt.push_back(mk(1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h000));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h000));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'h100));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 32'h0c, 1'b1, 32'h4, 32'h104));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'h108));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hc, 32'h10c));
        // Core stalled: four requests, then credit runs out; release resumes at 0x10.
        vt.push_back(mk(1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 32'h000));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0, 32'h000));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0, 32'h100));
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0c, 1'b1, 32'h0, 32'h100));
        vt.push_back(mk(1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 32'h100));
        vt.push_back(mk(1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 32'h100));
        vt.push_back(mk(1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 32'h100));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4, 32'h104));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8, 32'h108));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'hc, 32'h10c));
        vt.push_back(mk(1'b0, 1'b1, 1'b1, 32'h1c, 1'b1, 32'h10, 32'h110));

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outs("init");

        lat = 1;
        mem_req_ready = 1'b1;
        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            else @(negedge clk);
            instr_ready = vt[i].ir;
            #1;
            chk($sformatf("v%0d_req_valid", i), 32'(mem_req_valid), 32'(vt[i].rv));
            chk($sformatf("v%0d_req_addr", i), mem_req_addr, vt[i].ra);
            chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vt[i].iv));
            chk($sformatf("v%0d_instr_pc", i), instr_pc, vt[i].ipc);
            chk($sformatf("v%0d_instr", i), instr, vt[i].ins);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'd4);
`endif

        // Redirect with three requests in flight at latency 3.
        lat = 3;
        instr_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        instr_ready = 1'b0;
        #1;
        chk("A_redir_gate", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        redirect    = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("A_drain1", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("A_drain2", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("A_refetch_valid", 32'(mem_req_valid), 32'd1);
        chk("A_refetch_addr", mem_req_addr, 32'h40);
        wait_valid("A_first", pc, ins);
        chk("A_first_pc", pc, 32'h40);
        chk("A_first_instr", ins, 32'h140);

        // Back-to-back redirects, the second one during drain.
        do_reset();
        @(negedge clk);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        instr_ready = 1'b0;
        #1;
        chk("B_gate1", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        redirect_pc = 32'hC0;
        #1;
        chk("B_gate2", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        redirect    = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("B_drain", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("B_refetch_valid", 32'(mem_req_valid), 32'd1);
        chk("B_refetch_addr", mem_req_addr, 32'hC0);
        wait_valid("B_first", pc, ins);
        chk("B_first_pc", pc, 32'hC0);
        chk("B_first_instr", ins, 32'h1C0);
`ifdef FETCH_PERF_EN
        chk("perf_flushes", perf_flushes, 32'd2);
`endif

        // Request-side backpressure.
        lat = 1;
        pat = 16'b1011_0010_1101_0011;
        exp_addr = 32'h0;
        exp_pc = 32'h0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i != 0) @(negedge clk);
            mem_req_ready = pat[i % 16];
            #1;
            if (mem_req_valid) begin
                chk($sformatf("C%0d_addr", i), mem_req_addr, exp_addr);
                if (mem_req_ready) exp_addr = exp_addr + 32'd4;
            end
            if (instr_valid) begin
                chk($sformatf("C%0d_pc", i), instr_pc, exp_pc);
                chk($sformatf("C%0d_instr", i), instr, exp_pc + 32'h100);
                exp_pc = exp_pc + 32'd4;
            end
        end
        chk("C_progress", 32'(exp_pc >= 32'd16), 32'd1);

        // Address wrap at the top of memory.
        mem_req_ready = 1'b1;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("D_gate", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("D_addr_top", mem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("D_addr_wrap", mem_req_addr, 32'h0);
        wait_valid("D_first", pc, ins);
        chk("D_first_pc", pc, 32'hFFFF_FFFC);
        chk("D_first_instr", ins, 32'h0000_00FC);
        @(negedge clk);
        #1;
        chk("D_next_pc", instr_pc, 32'h0);
        chk("D_next_instr", instr, 32'h100);

        // Asynchronous reset in the middle of a burst.
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outs("E_midreset");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle core's decode/execute datapath.
- Generates sequential word addresses to a latency-variable instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers {pc, instr} pairs in a small FIFO and presents them to the core over a valid/ready channel.
- Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and also the maximum number of outstanding memory requests (power of 2, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  32  byte address of the request; bits [1:0] are always 0.
- mem_rsp_valid  in  1  response data valid (in order, one per accepted request, never before the cycle after acceptance).
- mem_rsp_data  in  32  instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  core consumes the head this cycle.
- instr  out  32  head instruction.
- instr_pc  out  32  head PC.
- redirect  in  1  taken branch or jump: flush and refetch.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard_cnt=0; state=FETCH.
  - Outputs: mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, mem_req_addr=RESET_PC.
  - Reset asserted mid-operation abandons everything. Responses arriving after reset deassertion for pre-reset requests are outside the memory contract and do not occur.
- Credit:
  - mem_req_valid=1 only when state=FETCH and count+outstanding < DEPTH. count includes entries being written this cycle.
  - mem_req_addr=fetch_pc, held stable while valid&&!ready.
  - On valid&&ready: fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC → 0); outstanding++.
  - A FIFO-side queue of PCs, DEPTH deep, records each issued address.
- Response:
  - Each mem_rsp_valid decrements outstanding.
  - If discard_cnt>0: data is dropped, discard_cnt--.
  - Otherwise {pc_queue head, mem_rsp_data} is pushed. Overflow is impossible by the credit rule.
- Output:
  - The head is shown combinationally from FIFO registers, so zero-latency presentation once written.
  - Pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle is legal at any fill level, including full.
  - Minimum latency: request accepted cycle N, response N+1, instr_valid N+2.
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO and PC queue are cleared; the pop that cycle is ignored and the core must not consume when redirect=1.
  - fetch_pc = redirect_pc & ~3.
  - discard_cnt = outstanding after this cycle's accept/response updates, i.e. the count of requests still unanswered.
  - state = DRAIN if that value is nonzero, else FETCH.
  - mem_req_valid is forced to 0 in the redirect cycle.
- FSM:
  - FETCH: issue per credit.
  - DRAIN: no issue; advance to FETCH in the cycle discard_cnt reaches 0 (the edge where the last stale response is dropped).
  - Redirect during DRAIN reloads discard_cnt and fetch_pc and stays in DRAIN.
- Empty FIFO: instr_valid=0; instr and instr_pc keep the last popped values (no X).

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetched[31:0] (count of instructions popped by the core) and perf_flushes[31:0] (count of redirects). Both reset to 0, wrap at 2^32, increment at most 1 per cycle each.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}
  - typedef fetch_state_t enum {FETCH, DRAIN}
  - localparam WORD_BYTES=4
- Sub-module fetch_fifo:
  - Parameterised by DEPTH and entry type.
  - Ports: push, pop, flush, full, empty, count.
  - Instantiated twice: entry FIFO, and PC queue with 32-bit entries.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle memory returning addr+32'h100, instr_ready=1 → addresses 0,4,8,…; instr_pc=0 and instr=32'h100 at cycle 2 after release, then one instruction per cycle.
- instr_ready=0 held → exactly 4 (DEPTH) requests issued, FIFO fills, mem_req_valid drops to 0. Release ready → resumes at addr 16 with no lost or duplicated PC.
- Memory latency 3 with 3 requests outstanding, redirect_pc=32'h0000_0043 → next request addr 32'h40 only after 3 stale responses are dropped; first delivered instr_pc=32'h40.
- Back-to-back redirects (0x80, then 0xC0 next cycle while in DRAIN) → first delivered instr_pc=0xC0; nothing from 0x80 is delivered.
- mem_req_ready toggling 0/1 → mem_req_addr stable while stalled; PCs strictly sequential.
- fetch_pc=32'hFFFF_FFFC → next address 0; reset asserted mid-burst → all outputs return to reset values immediately. With FETCH_PERF_EN: perf_flushes increments per redirect.
